// File: rtl/adc_capture_if.sv
// Bus bundle between adc_capture and its surroundings: the LTC2308 serial pins
// plus the captured-sample output with its write strobe.
interface adc_capture_if;
    logic        adc_convst;
    logic        adc_sck;
    logic        adc_sdi;
    logic        adc_sdo;
    logic [11:0] data;
    logic        data_valid;
    logic        sampleClock;

    modport master (
        output adc_convst, adc_sck, adc_sdi, data, data_valid, sampleClock,
        input  adc_sdo
    );

    modport slave (
        input  adc_convst, adc_sck, adc_sdi, data, data_valid, sampleClock,
        output adc_sdo
    );
endinterface

// File: rtl/adc_capture.sv
// Free-running LTC2308 conversion sequencer: CONVST pulse, conversion wait,
// 12-bit SPI exchange, then publishes the sample with a write strobe.
module adc_capture #(
    parameter int CLK_DIV       = 2,
    parameter int CONVST_CYCLES = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int CHANNEL       = 0,
    parameter int UNIPOLAR      = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    adc_capture_if.master bus
);
    localparam int SUM = CLK_DIV * 2 + CONVST_CYCLES + CONV_CYCLES;
    localparam int CW  = ($clog2(SUM + 1) < 8) ? 8 : $clog2(SUM + 1);

    localparam logic [CW-1:0] CS_LAST  = CW'(CONVST_CYCLES - 1);
    localparam logic [CW-1:0] CV_LAST  = CW'(CONV_CYCLES - 1);
    localparam logic [CW-1:0] LO_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(2 * CLK_DIV - 1);

    localparam logic [2:0] CH  = 3'(CHANNEL);
    localparam logic       UNI = (UNIPOLAR != 0);
    // Config word in transmit order, bit 0 first: S/D, O/S, S1, S0, UNI, SLP.
    localparam logic [15:0] SDI_WORD = {10'b0, 1'b0, UNI, CH[1], CH[2], CH[0], 1'b1};

    typedef enum logic [2:0] {IDLE, CONVST, CONV_WAIT, SHIFT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [11:0]   sr;
    logic          first_frame;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            sr              <= '0;
            first_frame     <= 1'b1;
            bus.adc_convst  <= 1'b0;
            bus.adc_sck     <= 1'b0;
            bus.adc_sdi     <= 1'b0;
            bus.data        <= '0;
            bus.data_valid  <= 1'b0;
            bus.sampleClock <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            // Strobe rises the cycle after data_valid so data is already settled.
            if (bus.data_valid) bus.sampleClock <= 1'b1;
            case (state)
                IDLE: begin
                    bus.adc_convst <= 1'b0;
                    bus.adc_sck    <= 1'b0;
                    if (enable) begin
                        state           <= CONVST;
                        cnt             <= '0;
                        bus.adc_convst  <= 1'b1;
                        bus.sampleClock <= 1'b0;
                    end
                end
                CONVST: begin
                    if (cnt == CS_LAST) begin
                        state          <= CONV_WAIT;
                        cnt            <= '0;
                        bus.adc_convst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CONV_WAIT: begin
                    if (cnt == CV_LAST) begin
                        state       <= SHIFT;
                        cnt         <= '0;
                        bit_idx     <= '0;
                        bus.adc_sdi <= SDI_WORD[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == LO_LAST) begin
                        bus.adc_sck <= 1'b1;
                        sr          <= {sr[10:0], bus.adc_sdo};
                    end
                    if (cnt == BIT_LAST) begin
                        bus.adc_sck <= 1'b0;
                        cnt         <= '0;
                        if (bit_idx == 4'd11) begin
                            state       <= DONE;
                            bus.adc_sdi <= 1'b0;
                        end else begin
                            bit_idx     <= bit_idx + 4'd1;
                            bus.adc_sdi <= SDI_WORD[bit_idx + 4'd1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // First frame after reset ran with an unknown ADC config.
                    if (first_frame) begin
                        first_frame <= 1'b0;
                    end else begin
                        bus.data       <= sr;
                        bus.data_valid <= 1'b1;
                    end
                    cnt <= '0;
                    if (enable) begin
                        state           <= CONVST;
                        bus.adc_convst  <= 1'b1;
                        bus.sampleClock <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
